alu_dec_md: RTL and testbench
=============================

Name: alu_dec_md

Overview:
Parametrised successor to the multicycle ALU decoder. It keeps the alu_op/funct decode to ALU control, widens the control code to 4 bits and adds xor, nor and sltu. It also adds an iterative multiply/divide unit with HI/LO registers for mult, multu, div, divu, mfhi, mflo, mthi and mtlo. It sits between the main controller FSM and the datapath; the controller stalls in execute while md_busy is high.

Parameters:
WIDTH, 32, datapath width of src_a, src_b, HI, LO and md_out (must be at least 2).
CNT_W, $clog2(WIDTH+1), iteration counter width.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  reset, asynchronous, active-high
alu_op  in  2  from controller: 00 add, 01 sub, 10 R-type (use funct), 11 or (ori)
funct  in  6  instruction funct field
start  in  1  one-cycle pulse from the controller in the execute state
src_a  in  WIDTH  rs operand
src_b  in  WIDTH  rt operand
alu_control  out  4  ALU operation code (combinational)
illegal  out  1  alu_op=10 with an unrecognised funct (combinational)
md_busy  out  1  mult/div iteration in progress
md_done  out  1  one-cycle pulse when HI/LO have been written by mult/div
md_out  out  WIDTH  HI when funct=010000, otherwise LO (combinational)

Behaviour:
- Decode (combinational):
  - alu_op 00 -> 0010; 01 -> 0110; 11 -> 0001.
  - alu_op 10, funct: 100000/100001 -> 0010; 100010/100011 -> 0110; 100100 -> 0000; 100101 -> 0001; 100110 -> 0011; 100111 -> 0100; 101010 -> 0111; 101011 -> 0101.
  - mfhi (010000) and mflo (010010) -> 1001, meaning the ALU passes md_out.
  - mult/multu/div/divu/mthi/mtlo (011000/011001/011010/011011/010001/010011) -> 1111 (no ALU write).
  - Any other funct -> 0000 with illegal=1. The output is never X.
- md command accepted = start & alu_op==10 & funct is a md op & state IDLE. start in any other case is ignored with no state change.
- mthi/mtlo: HI or LO <= src_a on the accepting edge. No busy, no done.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on accepted mult/multu/div/divu. On that edge: latch op, latch |src_a| and |src_b| (raw values for unsigned ops), latch the sign flags, clear the accumulator, count <= 0.
  - RUN: one radix-2 step per cycle. Multiply is shift-add over 2*WIDTH bits. Divide is restoring: shift the remainder, trial-subtract the divisor, set the quotient bit. count increments each step. Exit to DONE after WIDTH steps.
  - RUN -> DONE edge: write HI/LO with sign correction.
    - mult: {HI,LO} = negated product if sign_a^sign_b.
    - div: LO = quotient, negated if sign_a^sign_b; HI = remainder with the sign of the dividend.
  - DONE -> IDLE unconditionally after one cycle.
- Handshake:
  - md_busy=1 exactly while in RUN, i.e. WIDTH cycles.
  - md_done=1 only in DONE.
  - HI/LO hold their old values until the DONE write.
  - The first edge after accept is cycle 1; md_done is high in cycle WIDTH+1.
- Divide by zero (src_b=0): same latency, no special state. Result is LO = all ones, HI = src_a (the natural restoring output for unsigned operands). Signed div by zero gives the same values and bypasses sign correction.
- Most-negative operand: abs(most-negative) is held as an unsigned WIDTH-bit value. Example: div 0x80000000 / -1 -> LO=0x80000000, HI=0.
- mfhi/mflo during RUN return the old HI/LO. The controller is responsible for stalling.
- Reset (any time, including mid-RUN): state IDLE; HI, LO, accumulator and counter <= 0; md_busy=0, md_done=0. Combinational outputs follow their inputs.

Test Plan:
- Decode sweep: all alu_op values plus every listed funct -> alu_control matches the table. Funct 000111 -> alu_control=0000, illegal=1.
- mult, src_a=0xFFFFFFFD (-3), src_b=7 -> md_busy high for 32 cycles, md_done in cycle 33. Then HI=0xFFFFFFFF, LO=0xFFFFFFEB; mflo gives md_out=0xFFFFFFEB.
- divu 100/7 -> LO=14, HI=2. div 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div 5/0 -> LO=0xFFFFFFFF, HI=5 at md_done, same 33-cycle latency. Second start pulse during RUN -> ignored, HI/LO unchanged until the first op completes.
- mthi src_a=0x1234 then mfhi -> md_out=0x1234 on the next cycle, no md_busy. mult while HI=0x1234 -> mfhi reads 0x1234 until md_done.
- reset asserted in cycle 10 of a mult -> md_busy=0 immediately, HI=LO=0. A new mult after reset release completes with correct values.

Source files
------------

// File: rtl/alu_dec_md.sv
// ALU control decoder with an iterative radix-2 multiply/divide unit and HI/LO registers.
// mult/div take WIDTH cycles in RUN, then pulse md_done for one cycle while HI/LO hold the result.
module alu_dec_md #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic             start,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [3:0]       alu_control,
    output logic             illegal,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] md_out
);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_hi, r_lo, r_a, r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_div, r_neg_q, r_neg_r, r_busy, r_done;

    logic                 w_md_op, w_iter, w_accept, w_sgn, w_sa, w_sb;
    logic [WIDTH-1:0]     w_abs_a, w_abs_b;
    logic [WIDTH:0]       w_sum, w_rem_sh;
    logic [WIDTH-1:0]     w_diff, w_rem_nx, w_q, w_r, w_q_neg, w_r_neg;
    logic                 w_ge;
    logic [2*WIDTH-1:0]   w_acc_nx, w_prod_neg;

    always_comb begin
        alu_control = '0;
        illegal     = 1'b0;
        w_md_op     = 1'b0;
        case (alu_op)
            2'b00: alu_control = 4'b0010;
            2'b01: alu_control = 4'b0110;
            2'b11: alu_control = 4'b0001;
            2'b10: begin
                case (funct)
                    6'b100000, 6'b100001: alu_control = 4'b0010;
                    6'b100010, 6'b100011: alu_control = 4'b0110;
                    6'b100100:            alu_control = 4'b0000;
                    6'b100101:            alu_control = 4'b0001;
                    6'b100110:            alu_control = 4'b0011;
                    6'b100111:            alu_control = 4'b0100;
                    6'b101010:            alu_control = 4'b0111;
                    6'b101011:            alu_control = 4'b0101;
                    F_MFHI, F_MFLO:       alu_control = 4'b1001;
                    F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO: begin
                        alu_control = 4'b1111;
                        w_md_op     = 1'b1;
                    end
                    default:              illegal = 1'b1;
                endcase
            end
        endcase
    end

    assign w_iter   = (funct[5:2] == 4'b0110);
    assign w_accept = start && (alu_op == 2'b10) && w_md_op && (r_state == S_IDLE);

    // Signed divide by zero is run as unsigned so HI comes back as the raw dividend.
    assign w_sgn   = ~funct[0] & ~(funct[1] & (src_b == '0));
    assign w_sa    = w_sgn & src_a[WIDTH-1];
    assign w_sb    = w_sgn & src_b[WIDTH-1];
    assign w_abs_a = w_sa ? -src_a : src_a;
    assign w_abs_b = w_sb ? -src_b : src_b;

    // Multiply: upper half accumulates, product bits shift down into the lower half.
    assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_a[0] ? {1'b0, r_b} : '0);
    // Divide: upper half is the remainder, quotient bits shift into the lower half.
    assign w_rem_sh = {r_acc[2*WIDTH-1:WIDTH], r_a[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_b});
    assign w_diff   = w_rem_sh[WIDTH-1:0] - r_b;
    assign w_rem_nx = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
    assign w_acc_nx = r_div ? {w_rem_nx, r_acc[WIDTH-2:0], w_ge}
                            : {w_sum, r_acc[WIDTH-1:1]};

    assign w_q        = w_acc_nx[WIDTH-1:0];
    assign w_r        = w_acc_nx[2*WIDTH-1:WIDTH];
    assign w_q_neg    = -w_q;
    assign w_r_neg    = -w_r;
    assign w_prod_neg = -w_acc_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_hi    <= '0;
            r_lo    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        if (w_iter) begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                            r_div   <= funct[1];
                            r_a     <= w_abs_a;
                            r_b     <= w_abs_b;
                            r_neg_q <= w_sa ^ w_sb;
                            r_neg_r <= w_sa;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                        end else if (funct[1]) begin
                            r_lo <= src_a;
                        end else begin
                            r_hi <= src_a;
                        end
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_nx;
                    r_a   <= r_div ? (r_a << 1) : (r_a >> 1);
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        if (r_div) begin
                            r_lo <= r_neg_q ? w_q_neg : w_q;
                            r_hi <= r_neg_r ? w_r_neg : w_r;
                        end else begin
                            {r_hi, r_lo} <= r_neg_q ? w_prod_neg : w_acc_nx;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign md_busy = r_busy;
    assign md_done = r_done;
    assign md_out  = (funct == F_MFHI) ? r_hi : r_lo;

endmodule

// File: tb/tb_alu_dec_md.sv
// Directed bench for alu_dec_md: an arithmetic reference model checked every cycle,
// plus literal expectations for the documented example operations.
module tb_alu_dec_md;

    localparam int WIDTH = 32;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       alu_op = 2'b00;
    logic [5:0]       funct = 6'b000000;
    logic             start = 1'b0;
    logic [WIDTH-1:0] src_a = '0;
    logic [WIDTH-1:0] src_b = '0;
    logic [3:0]       alu_control;
    logic             illegal, md_busy, md_done;
    logic [WIDTH-1:0] md_out;

    int n_tests = 0;
    int n_fail  = 0;

    alu_dec_md #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .alu_op(alu_op), .funct(funct), .start(start),
        .src_a(src_a), .src_b(src_b), .alu_control(alu_control), .illegal(illegal),
        .md_busy(md_busy), .md_done(md_done), .md_out(md_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void dec_ref(input logic [1:0] op, input logic [5:0] f,
                                    output logic [3:0] c, output logic il);
        il = 1'b0;
        case (op)
            2'b00: c = 4'b0010;
            2'b01: c = 4'b0110;
            2'b11: c = 4'b0001;
            default: begin
                case (f)
                    6'b100000, 6'b100001: c = 4'b0010;
                    6'b100010, 6'b100011: c = 4'b0110;
                    6'b100100: c = 4'b0000;
                    6'b100101: c = 4'b0001;
                    6'b100110: c = 4'b0011;
                    6'b100111: c = 4'b0100;
                    6'b101010: c = 4'b0111;
                    6'b101011: c = 4'b0101;
                    F_MFHI, F_MFLO: c = 4'b1001;
                    F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO: c = 4'b1111;
                    default: begin c = 4'b0000; il = 1'b1; end
                endcase
            end
        endcase
    endfunction

    function automatic void md_ref(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            F_MULT:  p = sa * sb;
            F_MULTU: p = {32'b0, a} * {32'b0, b};
            F_DIV: begin
                if (b == 0) p = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) p = {a, 32'hFFFFFFFF};
                else p = {a % b, a / b};
            end
        endcase
        hi = p[63:32];
        lo = p[31:0];
    endfunction

    // Reference timeline: result appears WIDTH edges after the accepting edge, done for one cycle.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

    always @(posedge clk or posedge reset) begin
        int          left;
        logic        idle;
        logic [31:0] hi, lo, nh, nl;
        if (reset) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else begin
            idle = (m_left == 0) && !m_done;
            left = m_left;
            hi   = m_hi;
            lo   = m_lo;
            m_done <= 1'b0;
            if (left > 0) begin
                left = left - 1;
                if (left == 0) begin
                    hi = p_hi;
                    lo = p_lo;
                    m_done <= 1'b1;
                end
            end
            if (idle && start && alu_op == 2'b10) begin
                case (funct)
                    F_MTHI: hi = src_a;
                    F_MTLO: lo = src_a;
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        md_ref(funct, src_a, src_b, nh, nl);
                        p_hi <= nh;
                        p_lo <= nl;
                        left = WIDTH;
                    end
                    default: ;
                endcase
            end
            m_left <= left;
            m_hi   <= hi;
            m_lo   <= lo;
        end
    end

    always @(negedge clk) begin
        logic [3:0] c;
        logic       il;
        dec_ref(alu_op, funct, c, il);
        check("alu_control", alu_control, c);
        check("illegal", illegal, il);
        check("md_busy", md_busy, m_left > 0);
        check("md_done", md_done, m_done);
        check("md_out", md_out, (funct == F_MFHI) ? m_hi : m_lo);
    end

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk); #2;
        alu_op = 2'b10; funct = f; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hold, input logic [31:0] ehi, input logic [31:0] elo,
                          input int extra_at);
        int lat = 0;
        int nbusy = 0;
        issue(f, a, b);
        funct = F_MFHI;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk); #1;
            if (md_busy) nbusy++;
            if (c == 1 || c == WIDTH) check("hi_held", md_out, hold);
            if (c == extra_at) begin
                start = 1'b1; funct = F_MULT; src_a = 32'd9; src_b = 32'd9;
                @(posedge clk); #1;
                start = 1'b0; funct = F_MFHI;
            end
            if (md_done) begin
                lat = c;
                break;
            end
        end
        check("done_cycle", lat, WIDTH + 1);
        check("busy_cycles", nbusy, WIDTH);
        check("hi_result", md_out, ehi);
        funct = F_MFLO; #1;
        check("lo_result", md_out, elo);
    endtask

    initial begin
        logic [5:0] fl[20];
        fl = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100110,
               6'b100111, 6'b101010, 6'b101011, F_MFHI, F_MFLO, F_MULT, F_MULTU, F_DIV,
               F_DIVU, F_MTHI, F_MTLO, 6'b000111, 6'b111111};

        #1 reset = 1'b1;
        #1;
        check("rst_busy", md_busy, 1'b0);
        check("rst_done", md_done, 1'b0);
        check("rst_md_out", md_out, 32'h0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;

        for (int op = 0; op < 4; op++) begin
            @(negedge clk); #2;
            alu_op = op[1:0]; funct = 6'b101010;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #2;
            alu_op = 2'b10; funct = fl[i];
        end
        @(negedge clk); #2;
        funct = 6'b000111; #1;
        check("dec_000111_ctl", alu_control, 4'b0000);
        check("dec_000111_ill", illegal, 1'b1);
        funct = 6'b100110; #1;
        check("dec_xor", alu_control, 4'b0011);
        funct = 6'b101011; #1;
        check("dec_sltu", alu_control, 4'b0101);
        alu_op = 2'b11; #1;
        check("dec_ori", alu_control, 4'b0001);

        run_md(F_MULT,  32'hFFFFFFFD, 32'd7,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        run_md(F_DIVU,  32'd100,      32'd7,        32'hFFFFFFFF, 32'd2,        32'd14,       0);
        run_md(F_DIV,   32'hFFFFFFF9, 32'd2,        32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_md(F_DIV,   32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, 5);
        run_md(F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd5,        32'h0,        32'h80000000, 0);
        run_md(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFE, 32'h00000001, 0);
        run_md(F_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFFE, 32'hFFFFFFF9, 32'hFFFFFFFF, 0);

        issue(F_MTHI, 32'h1234, 32'h0);
        funct = F_MFHI;
        @(negedge clk); #1;
        check("mthi_read", md_out, 32'h1234);
        check("mthi_no_busy", md_busy, 1'b0);
        issue(F_MTLO, 32'h55, 32'h0);
        funct = F_MFLO;
        @(negedge clk); #1;
        check("mtlo_read", md_out, 32'h55);

        run_md(F_MULT, 32'd6, 32'hFFFFFFFB, 32'h1234, 32'hFFFFFFFF, 32'hFFFFFFE2, 0);

        issue(F_MULT, 32'd123, 32'd456);
        repeat (10) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_busy", md_busy, 1'b0);
        check("midrst_done", md_done, 1'b0);
        funct = F_MFHI; #1;
        check("midrst_hi", md_out, 32'h0);
        funct = F_MFLO; #1;
        check("midrst_lo", md_out, 32'h0);
        @(negedge clk); #2 reset = 1'b0;

        run_md(F_MULT, 32'h10000, 32'h10000, 32'h0, 32'h1, 32'h0, 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
